// File: rtl/mem_arb_pkg.sv
// Shared encodings for the I/D-cache memory arbiter.
// State values and owner tags are visible so the bench and any debug logic can decode them.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_I = 2'b01,
        OWN_D = 2'b10,
        DRAIN = 2'b11
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/arb_tag_pipe.sv
// Read-return tag pipeline: one {valid, owner} entry per accepted read, aged MEM_LAT cycles
// so the tail lines up with the memory's read data.
module arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic load_owner,
    output logic empty,
    output logic tail_vld,
    output logic tail_owner
);

    logic [MEM_LAT-1:0] vld_pipe;
    logic [MEM_LAT-1:0] own_pipe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            own_pipe <= {MEM_LAT{OWNER_I}};
        end else begin
            vld_pipe[0] <= load;
            own_pipe[0] <= load_owner;
            for (int k = 1; k < MEM_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                own_pipe[k] <= own_pipe[k-1];
            end
        end
    end

    assign empty      = ~|vld_pipe;
    assign tail_vld   = vld_pipe[MEM_LAT-1];
    assign tail_owner = own_pipe[MEM_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Burst-granularity arbiter sharing main memory between the I-cache and D-cache controllers.
// The owner's strobes pass straight through; read data is steered back by a latency-matched tag.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          i_req,
    input  logic          i_rd,
    input  logic          i_wr,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic          i_grant,
    output logic          i_stall,
    output logic [DW-1:0] i_rdata,
    output logic          i_rvalid,
    output logic          i_err,

    input  logic          d_req,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_grant,
    output logic          d_stall,
    output logic [DW-1:0] d_rdata,
    output logic          d_rvalid,
    output logic          d_err,

    output logic          m_rd,
    output logic          m_wr,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_data_out,
    input  logic          m_stall,
    input  logic          m_err
);

    arb_state_e state, state_nxt;
    logic       last_owner, last_nxt;

    logic own_i, own_d, owned;
    logic own_rd, own_wr;
    logic proto_err, err_any, err_owner;
    logic tag_load;
    logic pipe_empty, tail_vld, tail_owner;

    assign own_i = (state == OWN_I);
    assign own_d = (state == OWN_D);
    assign owned = own_i | own_d;

    // Only the owner's strobes are looked at; everything else is dropped here.
    assign own_rd = owned & (own_d ? d_rd : i_rd);
    assign own_wr = owned & (own_d ? d_wr : i_wr);

    assign proto_err = own_rd & own_wr;
    assign m_rd      = own_rd & ~own_wr;
    assign m_wr      = own_wr & ~own_rd;
    assign m_addr    = owned ? (own_d ? d_addr  : i_addr)  : '0;
    assign m_wdata   = owned ? (own_d ? d_wdata : i_wdata) : '0;

    assign tag_load  = m_rd & ~m_stall;

    arb_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .load       (tag_load),
        .load_owner (own_d),
        .empty      (pipe_empty),
        .tail_vld   (tail_vld),
        .tail_owner (tail_owner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_owner <= OWNER_I;
        end else begin
            state      <= state_nxt;
            last_owner <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last_owner;
        case (state)
            IDLE: begin
                if (i_req && d_req)
                    state_nxt = (last_owner == OWNER_I) ? OWN_D : OWN_I;
                else if (i_req)
                    state_nxt = OWN_I;
                else if (d_req)
                    state_nxt = OWN_D;
            end
            OWN_I: begin
                if (!i_req) begin
                    last_nxt  = OWNER_I;
                    // A read accepted this very cycle is not in the pipe yet, so count it too.
                    state_nxt = (tag_load || !pipe_empty) ? DRAIN : IDLE;
                end
            end
            OWN_D: begin
                if (!d_req) begin
                    last_nxt  = OWNER_D;
                    state_nxt = (tag_load || !pipe_empty) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (pipe_empty)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign i_grant = own_i;
    assign d_grant = own_d;
    assign i_stall = ~i_grant | m_stall;
    assign d_stall = ~d_grant | m_stall;

    assign i_rdata  = m_data_out;
    assign d_rdata  = m_data_out;
    assign i_rvalid = tail_vld & (tail_owner == OWNER_I);
    assign d_rvalid = tail_vld & (tail_owner == OWNER_D);

    // Memory errors during drain belong to the burst that just released.
    assign err_owner = owned ? own_d : last_owner;
    assign err_any   = proto_err | (m_err & (state != IDLE));
    assign i_err     = err_any & (err_owner == OWNER_I);
    assign d_err     = err_any & (err_owner == OWNER_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-vector bench for mem_arbiter: each record is one clock of inputs plus the expected outputs.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_rd, i_wr, d_req, d_rd, d_wr;
    logic [15:0] i_addr, i_wdata, d_addr, d_wdata;
    logic        i_grant, i_stall, i_rvalid, i_err;
    logic        d_grant, d_stall, d_rvalid, d_err;
    logic [15:0] i_rdata, d_rdata;
    logic        m_rd, m_wr, m_stall, m_err;
    logic [15:0] m_addr, m_wdata, m_data_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DW(16), .AW(16), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_grant(i_grant), .i_stall(i_stall), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_err(i_err),
        .d_req(d_req), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_stall(d_stall), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_err(d_err),
        .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_data_out(m_data_out), .m_stall(m_stall), .m_err(m_err)
    );

    // ex bits: {i_grant,d_grant, i_stall,d_stall, m_rd,m_wr, i_rvalid,d_rvalid, i_err,d_err}
    typedef struct {
        logic        rs;
        logic        irq;
        logic [1:0]  irw;
        logic [15:0] iad;
        logic        drq;
        logic [1:0]  drw;
        logic [15:0] dad;
        logic        st;
        logic        me;
        logic [15:0] mdo;
        logic [9:0]  ex;
        logic [15:0] ead;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rs, input logic irq, input logic [1:0] irw, input logic [15:0] iad,
                       input logic drq, input logic [1:0] drw, input logic [15:0] dad,
                       input logic st, input logic me, input logic [15:0] mdo,
                       input logic [9:0] ex, input logic [15:0] ead);
        vec_t v;
        v.rs = rs; v.irq = irq; v.irw = irw; v.iad = iad;
        v.drq = drq; v.drw = drw; v.dad = dad;
        v.st = st; v.me = me; v.mdo = mdo; v.ex = ex; v.ead = ead;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst = v.rs;
        i_req = v.irq; i_rd = v.irw[1]; i_wr = v.irw[0]; i_addr = v.iad; i_wdata = v.iad ^ 16'h5500;
        d_req = v.drq; d_rd = v.drw[1]; d_wr = v.drw[0]; d_addr = v.dad; d_wdata = v.dad ^ 16'hAA00;
        m_stall = v.st; m_err = v.me; m_data_out = v.mdo;
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        logic [9:0]  got;
        logic [15:0] ewd;
        got = {i_grant, d_grant, i_stall, d_stall, m_rd, m_wr, i_rvalid, d_rvalid, i_err, d_err};
        checks++;
        if (got !== v.ex) begin
            errors++;
            $display("FAIL v%0d flags got=%b want=%b", idx, got, v.ex);
        end
        if (v.ex[5] | v.ex[4]) begin
            checks++;
            if (m_addr !== v.ead) begin
                errors++;
                $display("FAIL v%0d m_addr got=%h want=%h", idx, m_addr, v.ead);
            end
        end
        if (v.ex[4]) begin
            ewd = v.ex[9] ? (v.ead ^ 16'h5500) : (v.ead ^ 16'hAA00);
            checks++;
            if (m_wdata !== ewd) begin
                errors++;
                $display("FAIL v%0d m_wdata got=%h want=%h", idx, m_wdata, ewd);
            end
        end
        if (v.ex[3]) begin
            checks++;
            if (i_rdata !== v.mdo) begin
                errors++;
                $display("FAIL v%0d i_rdata got=%h want=%h", idx, i_rdata, v.mdo);
            end
        end
        if (v.ex[2]) begin
            checks++;
            if (d_rdata !== v.mdo) begin
                errors++;
                $display("FAIL v%0d d_rdata got=%h want=%h", idx, d_rdata, v.mdo);
            end
        end
    endtask

    localparam logic [1:0] RD = 2'b10, WR = 2'b01, RW = 2'b11;

    initial begin
        vec_t h;

        // reset, then lone D-cache read burst
        add(0, 0,0,0,       0,0,0,        0,0,0,       10'b00_11_00_00_00, 0);
        add(1, 0,0,0,       1,0,0,        0,0,0,       10'b00_11_00_00_00, 0);
        add(1, 0,0,0,       1,RD,16'h10,  0,0,0,       10'b01_10_10_00_00, 16'h10);
        add(1, 0,0,0,       1,RD,16'h11,  0,0,0,       10'b01_10_10_00_00, 16'h11);
        add(1, 0,0,0,       1,RD,16'h12,  0,0,16'hA000,10'b01_10_10_01_00, 16'h12);
        add(1, 0,0,0,       1,RD,16'h13,  0,0,16'hA001,10'b01_10_10_01_00, 16'h13);
        add(1, 0,0,0,       0,0,0,        0,0,16'hA002,10'b01_10_00_01_00, 0);
        add(1, 0,0,0,       0,0,0,        0,0,16'hA003,10'b00_11_00_01_00, 0);
        add(1, 0,0,0,       0,0,0,        0,0,0,       10'b00_11_00_00_00, 0);
        // re-reset, tie goes to D; non-owner I strobes ignored
        add(0, 0,0,0,       0,0,0,        0,0,0,       10'b00_11_00_00_00, 0);
        add(1, 1,0,0,       1,0,0,        0,0,0,       10'b00_11_00_00_00, 0);
        add(1, 1,RD,16'h99, 1,RD,16'h20,  0,0,0,       10'b01_10_10_00_00, 16'h20);
        add(1, 1,0,0,       0,0,0,        0,0,0,       10'b01_10_00_00_00, 0);
        add(1, 1,0,0,       0,0,0,        0,0,16'hB020,10'b00_11_00_01_00, 0);
        add(1, 1,0,0,       0,0,0,        0,1,0,       10'b00_11_00_00_01, 0);
        add(1, 1,0,0,       0,0,0,        0,0,0,       10'b00_11_00_00_00, 0);
        add(1, 1,WR,16'h30, 0,0,0,        0,1,0,       10'b10_01_01_00_10, 16'h30);
        add(1, 0,0,0,       1,0,0,        0,0,0,       10'b10_01_00_00_00, 0);
        add(1, 1,0,0,       1,0,0,        0,0,0,       10'b00_11_00_00_00, 0);
        add(1, 1,0,0,       1,0,0,        0,0,0,       10'b01_10_00_00_00, 0);
        add(1, 1,0,0,       0,0,0,        0,0,0,       10'b01_10_00_00_00, 0);
        // I write-back with a 3-cycle stall on word 2
        add(1, 1,0,0,       0,0,0,        0,0,0,       10'b00_11_00_00_00, 0);
        add(1, 1,WR,16'h100,0,0,0,        0,0,0,       10'b10_01_01_00_00, 16'h100);
        add(1, 1,WR,16'h101,0,0,0,        0,0,0,       10'b10_01_01_00_00, 16'h101);
        add(1, 1,WR,16'h102,0,0,0,        1,0,0,       10'b10_11_01_00_00, 16'h102);
        add(1, 1,WR,16'h102,0,0,0,        1,0,0,       10'b10_11_01_00_00, 16'h102);
        add(1, 1,WR,16'h102,0,0,0,        1,0,0,       10'b10_11_01_00_00, 16'h102);
        add(1, 1,WR,16'h102,0,0,0,        0,0,0,       10'b10_01_01_00_00, 16'h102);
        add(1, 1,WR,16'h103,0,0,0,        0,0,0,       10'b10_01_01_00_00, 16'h103);
        add(1, 0,0,0,       0,0,0,        0,0,0,       10'b10_01_00_00_00, 0);
        // I reads (one stalled), release on the last accepted read with D waiting
        add(1, 1,0,0,       0,0,0,        0,0,0,       10'b00_11_00_00_00, 0);
        add(1, 1,RD,16'h200,1,0,0,        0,0,0,       10'b10_01_10_00_00, 16'h200);
        add(1, 1,RD,16'h201,1,0,0,        1,0,0,       10'b10_11_10_00_00, 16'h201);
        add(1, 1,RD,16'h201,1,0,0,        0,0,16'hC200,10'b10_01_10_10_00, 16'h201);
        add(1, 1,RD,16'h202,1,0,0,        0,0,0,       10'b10_01_10_00_00, 16'h202);
        add(1, 0,RD,16'h203,1,0,0,        0,0,16'hC201,10'b10_01_10_10_00, 16'h203);
        add(1, 0,0,0,       1,0,0,        0,0,16'hC202,10'b00_11_00_10_00, 0);
        add(1, 0,0,0,       1,0,0,        0,0,16'hC203,10'b00_11_00_10_00, 0);
        add(1, 0,0,0,       1,0,0,        0,0,0,       10'b00_11_00_00_00, 0);
        add(1, 0,0,0,       1,0,0,        0,0,0,       10'b00_11_00_00_00, 0);
        // protocol error: rd and wr together
        add(1, 0,0,0,       1,RW,16'h40,  0,0,0,       10'b01_10_00_00_01, 0);
        add(1, 0,0,0,       0,0,0,        0,0,0,       10'b01_10_00_00_00, 0);
        add(1, 0,0,0,       1,0,0,        0,0,0,       10'b00_11_00_00_00, 0);
        add(1, 0,0,0,       1,RD,16'h50,  0,0,0,       10'b01_10_10_00_00, 16'h50);

        rst = 1'b1;
        i_req = 0; i_rd = 0; i_wr = 0; i_addr = 0; i_wdata = 0;
        d_req = 0; d_rd = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
        m_stall = 0; m_err = 0; m_data_out = 0;
        #1;

        foreach (vq[n]) begin
            drive(vq[n]);
            #3;
            check_vec(n, vq[n]);
            @(posedge clk);
            #1;
        end

        // reset between reads 1 and 2 of a D allocate: outputs drop at once, no data returns
        h = vq[vq.size()-1];
        h.dad = 16'h51;
        drive(h);
        #1;
        rst = 1'b0;
        #1;
        h.rs = 0; h.drq = 0; h.drw = 0; h.ex = 10'b00_11_00_00_00;
        check_vec(100, h);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            drive(h);
            #2;
            check_vec(101 + c, h);
        end
        h.rs = 1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            drive(h);
            #2;
            check_vec(103 + c, h);
        end
        // first tie after reset goes to D
        h.irq = 1; h.drq = 1;
        @(posedge clk); #1;
        drive(h);
        #2;
        check_vec(105, h);
        h.ex = 10'b01_10_00_00_00;
        @(posedge clk); #1;
        drive(h);
        #2;
        check_vec(106, h);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
